// File: rtl/moving_average1_inv_pkg.sv
// Shared types for the MovingAverage1 family: moving-sum encoder and its inverse.
//   MA1_WIDTH / MA1_DEPTH : default sample width and encoder window length
//   array_of_4_signed_8   : tap history at default sizes
//   inv_state_t           : decoder warm-up state
package MovingAverage1_types;

  localparam int unsigned MA1_WIDTH = 8;
  localparam int unsigned MA1_DEPTH = 4;

  typedef logic signed [MA1_WIDTH-1:0] array_of_4_signed_8 [MA1_DEPTH];
  typedef array_of_4_signed_8 array_of_DEPTH_signed_WIDTH;

  typedef enum logic {
    WARMUP = 1'b0,
    STEADY = 1'b1
  } inv_state_t;

endpackage

// File: rtl/moving_average1_inv_if.sv
// Valid/ready stream bundle for the moving-sum decoder.
//   in_valid/in_ready/in_sum           : encoded running-sum input
//   out_valid/out_ready/out_sample     : recovered sample output
//   out_warm                           : decoder history fully primed
//   master = upstream/downstream side, slave = decoder side
interface moving_average1_inv_if
  import MovingAverage1_types::*;
#(
  parameter int unsigned WIDTH = MA1_WIDTH
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_sum;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_sample;
  logic                    out_warm;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_sample, out_warm
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_sample, out_warm
  );
endinterface

// File: rtl/moving_average1_inv_hist.sv
// DEPTH-deep shift register of decoded samples; exposes the oldest tap.
//   system1000 / system1000_rstn : clock, async active-low reset
//   shift_en : push din (one accepted sample)
//   clr      : synchronous clear to the encoder's zero history
//   din      : newly decoded sample
//   oldest   : hist[DEPTH-1], the sample leaving the encoder window
module moving_average1_inv_hist
  import MovingAverage1_types::*;
#(
  parameter int unsigned WIDTH = MA1_WIDTH,
  parameter int unsigned DEPTH = MA1_DEPTH
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic                    shift_en,
  input  logic                    clr,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] oldest
);

  logic signed [WIDTH-1:0] hist_q [DEPTH];

  // Shift register: newest at index 0
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= '0;
    end else if (shift_en) begin
      hist_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign oldest = hist_q[DEPTH-1];

endmodule

// File: rtl/moving_average1_inv.sv
// Inverse of the DEPTH-tap moving-sum encoder: x[n] = y[n] - y[n-1] + x[n-DEPTH].
//   system1000      : clock, rising edge
//   system1000_rstn : async active-low reset
//   sync_clr        : synchronous realignment to encoder reset state
//   bus (slave)     : in_valid/in_ready/in_sum, out_valid/out_ready/out_sample, out_warm
module moving_average1_inv
  import MovingAverage1_types::*;
#(
  parameter int unsigned WIDTH = MA1_WIDTH,
  parameter int unsigned DEPTH = MA1_DEPTH
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                sync_clr,
  moving_average1_inv_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  inv_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    warm_q, warm_d;
  logic                    valid_q;
  logic signed [WIDTH-1:0] sample_q;
  logic signed [WIDTH-1:0] prev_q;
  logic signed [WIDTH-1:0] oldest;
  logic signed [WIDTH-1:0] x_c;
  logic                    ready_c;
  logic                    accept_c;

  // One-entry output register: accept whenever the slot is empty or draining
  assign ready_c  = !sync_clr && (!valid_q || bus.out_ready);
  assign accept_c = bus.in_valid && ready_c;

  // Modular difference restores the sample exactly across encoder wrap-around
  assign x_c = bus.in_sum - prev_q + oldest;

  moving_average1_inv_hist #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_hist (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .shift_en        (accept_c),
    .clr             (sync_clr),
    .din             (x_c),
    .oldest          (oldest)
  );

  // Warm-up FSM state register
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q <= WARMUP;
      cnt_q   <= '0;
      warm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
    end
  end

  // Warm-up FSM next state: count accepts until the window is full
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    if (sync_clr) begin
      state_d = WARMUP;
      cnt_d   = '0;
      warm_d  = 1'b0;
    end else if (accept_c) begin
      case (state_q)
        WARMUP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = STEADY;
            warm_d  = 1'b1;
          end
        end
        STEADY: ;
        default: state_d = WARMUP;
      endcase
    end
  end

  // Output register and previous-sum tracking
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      valid_q  <= 1'b0;
      sample_q <= '0;
      prev_q   <= '0;
    end else if (sync_clr) begin
      valid_q <= 1'b0;
      prev_q  <= '0;
    end else if (accept_c) begin
      valid_q  <= 1'b1;
      sample_q <= x_c;
      prev_q   <= bus.in_sum;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.out_valid  = valid_q;
  assign bus.out_sample = sample_q;
  assign bus.out_warm   = warm_q;

endmodule
